// File: rtl/gsm_pkg.sv
// gsm_pkg: shared constants for the GSM modem receive path.
// Optional +CSQ decode is enabled by defining GSM_RX_CSQ_EN.
package gsm_pkg;

  localparam int CLKS_PER_BIT_DEF = 2500;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] COMMA = 8'h2C;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] PLUS  = 8'h2B;

  localparam int CODE_W = 80;

  localparam logic [CODE_W-1:0] STR_OK =
    {64'd0, "OK"};
  localparam logic [CODE_W-1:0] STR_ERR =
    {40'd0, "ERROR"};
  localparam logic [CODE_W-1:0] STR_RING =
    {48'd0, "RING"};
  localparam logic [CODE_W-1:0] STR_NOCAR =
    "NO CARRIER";

  localparam int LEN_OK    = 2;
  localparam int LEN_ERR   = 5;
  localparam int LEN_RING  = 4;
  localparam int LEN_NOCAR = 10;

  localparam logic [47:0] STR_CSQ = "+CSQ: ";
  localparam int LEN_CSQ = 6;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } bit_st_t;

  function automatic logic is_digit(
    input logic [7:0] b
  );
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/gsm_uart_rx.sv
// gsm_uart_rx: 8N1 deserialiser with input synchroniser.
// Emits each good byte once; a low stop bit gives one frame_err.
module gsm_uart_rx
  import gsm_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_m;
  logic          rx_s;
  logic          rx_q;
  bit_st_t       st;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          stop_ok;

  // two-flop synchroniser plus a delay stage for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= line_rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  // bit-level receive FSM with registered byte outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      stop_ok   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      stop_ok   <= 1'b0;
      if (stop_ok) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end
      unique case (st)
        IDLE: begin
          if (rx_q && !rx_s) begin
            cnt  <= '0;
            bitn <= '0;
            st   <= START;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            st  <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bitn == 3'd7) st <= STOP;
            else bitn <= bitn + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (rx_s) begin
              stop_ok <= 1'b1;
              st      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              st        <= WAIT_HI;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          if (rx_s) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/gsm_rx.sv
// gsm_rx: modem UART receiver with result-code line matcher.
// Define GSM_RX_CSQ_EN to decode "+CSQ: <rssi>," lines.
module gsm_rx
  import gsm_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int LINE_MAX     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       resp_ok,
  output logic       resp_err,
  output logic       resp_ring,
  output logic       resp_nocar,
  output logic       line_ovf,
  output logic [6:0] csq_rssi,
  output logic       csq_valid
);

  localparam int CNTW = $clog2(LINE_MAX + 1);
  localparam int BW   = 8 * LINE_MAX;
  localparam logic [CNTW-1:0] CMAX =
    CNTW'(LINE_MAX);

  logic [BW-1:0]   sr;
  logic [CNTW-1:0] cnt;
  logic            bad;
  logic            ovf_seen;
  logic            is_cr;
  logic            is_lf;
  logic            push;
  logic            over;
  logic            eol_good;

  gsm_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_rx  (line_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  function automatic logic hit(
    input logic [BW-1:0]     s,
    input logic [CNTW-1:0]   n,
    input logic [CODE_W-1:0] code,
    input int                len
  );
    return (int'(n) == len) && (s == BW'(code));
  endfunction

  assign is_cr = rx_valid && (rx_data == CR);
  assign is_lf = rx_valid && (rx_data == LF);
  assign push  = rx_valid && !is_cr && !is_lf
              && (cnt != CMAX);
  assign over  = rx_valid && !is_cr && !is_lf
              && (cnt == CMAX);
  assign eol_good = is_lf && !bad && (cnt != '0);

  // line buffer and exact-match result-code classifier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      cnt        <= '0;
      bad        <= 1'b0;
      ovf_seen   <= 1'b0;
      resp_ok    <= 1'b0;
      resp_err   <= 1'b0;
      resp_ring  <= 1'b0;
      resp_nocar <= 1'b0;
      line_ovf   <= 1'b0;
    end else begin
      resp_ok    <= 1'b0;
      resp_err   <= 1'b0;
      resp_ring  <= 1'b0;
      resp_nocar <= 1'b0;
      line_ovf   <= 1'b0;
      if (frame_err) bad <= 1'b1;
      unique case (1'b1)
        is_lf: begin
          resp_ok <= eol_good
            && hit(sr, cnt, STR_OK, LEN_OK);
          resp_err <= eol_good
            && hit(sr, cnt, STR_ERR, LEN_ERR);
          resp_ring <= eol_good
            && hit(sr, cnt, STR_RING, LEN_RING);
          resp_nocar <= eol_good
            && hit(sr, cnt, STR_NOCAR, LEN_NOCAR);
          sr       <= '0;
          cnt      <= '0;
          bad      <= 1'b0;
          ovf_seen <= 1'b0;
        end
        push: begin
          sr  <= {sr[BW-9:0], rx_data};
          cnt <= cnt + 1'b1;
        end
        over: begin
          bad      <= 1'b1;
          ovf_seen <= 1'b1;
          line_ovf <= !ovf_seen;
        end
        default: ;
      endcase
    end
  end

`ifdef GSM_RX_CSQ_EN
  typedef enum logic [1:0] {
    CQ_PFX,
    CQ_DIG,
    CQ_DONE,
    CQ_BAD
  } cq_st_t;

  cq_st_t     cq_st;
  logic [1:0] cq_nd;
  logic [6:0] cq_v;
  logic [7:0] pfx_ch;

  // expected prefix character at the current line position
  always_comb begin
    pfx_ch = 8'h00;
    for (int i = 0; i < LEN_CSQ; i++) begin
      if (int'(cnt) == i)
        pfx_ch = STR_CSQ[8*(LEN_CSQ-1-i) +: 8];
    end
  end

  // incremental "+CSQ: d[d]," recogniser on appended bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq_st     <= CQ_PFX;
      cq_nd     <= '0;
      cq_v      <= '0;
      csq_rssi  <= '0;
      csq_valid <= 1'b0;
    end else begin
      csq_valid <= 1'b0;
      if (is_lf) begin
        if (eol_good && (cq_st == CQ_DONE)) begin
          csq_rssi  <= cq_v;
          csq_valid <= 1'b1;
        end
        cq_st <= CQ_PFX;
        cq_nd <= '0;
        cq_v  <= '0;
      end else if (push) begin
        unique case (cq_st)
          CQ_PFX: begin
            if (rx_data != pfx_ch)
              cq_st <= CQ_BAD;
            else if (int'(cnt) == LEN_CSQ - 1)
              cq_st <= CQ_DIG;
          end
          CQ_DIG: begin
            if (is_digit(rx_data)
                && (cq_nd != 2'd2)) begin
              cq_v <= 7'(cq_v * 7'd10)
                    + {3'b000, rx_data[3:0]};
              cq_nd <= cq_nd + 1'b1;
            end else if ((rx_data == COMMA)
                         && (cq_nd != 2'd0)) begin
              cq_st <= CQ_DONE;
            end else begin
              cq_st <= CQ_BAD;
            end
          end
          default: ;
        endcase
      end
    end
  end
`else
  assign csq_rssi  = '0;
  assign csq_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gsm_rx.sv
// tb_gsm_rx: table, directed and random line tests for gsm_rx.
// Define GSM_RX_CSQ_EN to exercise +CSQ decoding.
module tb_gsm_rx;

  localparam int CPB      = 16;
  localparam int LINE_MAX = 16;

  typedef logic [7:0] u8;
  typedef u8 q_t[$];

  typedef struct {
    logic [159:0] txt;
    int           len;
    int           bad_at;
    int           exp_resp;
    int           exp_ovf;
    int           exp_csq;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       line_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       resp_ok;
  logic       resp_err;
  logic       resp_ring;
  logic       resp_nocar;
  logic       line_ovf;
  logic [6:0] csq_rssi;
  logic       csq_valid;

  gsm_rx #(
    .CLKS_PER_BIT(CPB),
    .LINE_MAX    (LINE_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_rx   (line_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .resp_ok   (resp_ok),
    .resp_err  (resp_err),
    .resp_ring (resp_ring),
    .resp_nocar(resp_nocar),
    .line_ovf  (line_ovf),
    .csq_rssi  (csq_rssi),
    .csq_valid (csq_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int n_valid = 0, n_ferr = 0, n_ovf = 0, n_csq = 0;
  int n_ok = 0, n_err = 0, n_ring = 0, n_nocar = 0;
  int n_multi = 0;
  int last_valid_cyc = 0, last_resp_cyc = 0;
  int last_fall = 0;
  q_t rxq;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      rxq.push_back(rx_data);
      last_valid_cyc = cyc;
    end
    if (frame_err) n_ferr++;
    if (line_ovf) n_ovf++;
    if (csq_valid) n_csq++;
    if (resp_ok) n_ok++;
    if (resp_err) n_err++;
    if (resp_ring) n_ring++;
    if (resp_nocar) n_nocar++;
    if (resp_ok || resp_err || resp_ring || resp_nocar)
      last_resp_cyc = cyc;
    if (int'(resp_ok) + int'(resp_err)
        + int'(resp_ring) + int'(resp_nocar) > 1)
      n_multi++;
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string s,
                              input int ba,
                              input int er,
                              input int eo,
                              input int ec);
    vec_t v;
    v.txt = '0;
    for (int i = 0; i < s.len(); i++)
      v.txt = {v.txt[151:0], u8'(s[i])};
    v.len      = s.len();
    v.bad_at   = ba;
    v.exp_resp = er;
    v.exp_ovf  = eo;
    v.exp_csq  = ec;
    return v;
  endfunction

  function automatic q_t str_q(input string s);
    q_t q;
    for (int i = 0; i < s.len(); i++)
      q.push_back(u8'(s[i]));
    return q;
  endfunction

  function automatic q_t kept_of(input q_t t,
                                 input int ba);
    q_t k;
    for (int i = 0; i < t.size(); i++)
      if (i != ba && t[i] != 8'h0D)
        k.push_back(t[i]);
    return k;
  endfunction

  function automatic int model_resp(input q_t k,
                                    input bit bad);
    string s;
    s = "";
    if (bad || k.size() == 0 || k.size() > LINE_MAX)
      return 0;
    foreach (k[i]) s = $sformatf("%s%c", s, k[i]);
    if (s == "OK") return 1;
    if (s == "ERROR") return 2;
    if (s == "RING") return 3;
    if (s == "NO CARRIER") return 4;
    return 0;
  endfunction

  function automatic int csq_model(input q_t k,
                                   input bit bad);
    string pfx;
    int v, nd, i;
    pfx = "+CSQ: ";
    v = 0;
    nd = 0;
    if (bad || k.size() > LINE_MAX || k.size() < 8)
      return -1;
    for (i = 0; i < 6; i++)
      if (k[i] != u8'(pfx[i])) return -1;
    i = 6;
    while (i < k.size() && k[i] >= 8'h30
           && k[i] <= 8'h39) begin
      v = v * 10 + int'(k[i]) - 48;
      nd++;
      i++;
    end
    if (nd < 1 || nd > 2 || i >= k.size()) return -1;
    if (k[i] != 8'h2C) return -1;
    return v;
  endfunction

  task automatic send_byte(input u8 b, input bit good);
    line_rx = 1'b0;
    last_fall = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    line_rx = good;
    repeat (CPB) @(negedge clk);
    line_rx = 1'b1;
    if (!good) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_line(input string nm,
                           input q_t txt,
                           input int bad_at,
                           input int exp_resp,
                           input int exp_ovf,
                           input int exp_csq);
    int b_ok, b_err, b_ring, b_noc;
    int b_ovf, b_ferr, b_csq, mis;
    logic [31:0] act_r, exp_r;
    q_t exp_rx;
    b_ok = n_ok; b_err = n_err;
    b_ring = n_ring; b_noc = n_nocar;
    b_ovf = n_ovf; b_ferr = n_ferr; b_csq = n_csq;
    rxq.delete();
    for (int i = 0; i < txt.size(); i++) begin
      send_byte(txt[i], i != bad_at);
      if (i != bad_at) exp_rx.push_back(txt[i]);
    end
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
    exp_rx.push_back(8'h0D);
    exp_rx.push_back(8'h0A);
    repeat (4) @(negedge clk);
    act_r = {8'(n_ok - b_ok), 8'(n_err - b_err),
             8'(n_ring - b_ring), 8'(n_nocar - b_noc)};
    exp_r = {8'(exp_resp == 1), 8'(exp_resp == 2),
             8'(exp_resp == 3), 8'(exp_resp == 4)};
    chk({nm, ".resp"}, act_r, exp_r);
    chk({nm, ".ovf"}, n_ovf - b_ovf, exp_ovf);
    chk({nm, ".ferr"}, n_ferr - b_ferr,
        32'(bad_at >= 0));
    mis = 0;
    if (rxq.size() != exp_rx.size()) mis = 999;
    else foreach (exp_rx[i])
      if (rxq[i] !== exp_rx[i]) mis++;
    chk({nm, ".rxbytes"}, mis, 0);
    if (exp_resp != 0)
      chk({nm, ".resp_lat"},
          last_resp_cyc - last_valid_cyc, 1);
    chk({nm, ".csq_valid"}, n_csq - b_csq,
        32'(exp_csq >= 0));
    if (exp_csq >= 0)
      chk({nm, ".csq_rssi"}, 32'(csq_rssi), exp_csq);
  endtask

  function automatic logic [31:0] outs();
    return 32'({rx_data, rx_valid, frame_err,
                resp_ok, resp_err, resp_ring,
                resp_nocar, line_ovf, csq_rssi,
                csq_valid});
  endfunction

  vec_t tv[14];

  initial begin
    int b_valid, b_ferr, lat, ec;
    q_t t, k;
    string alpha;
    string codes[4];
    alpha = "OKERINGC A+S:12,";
    codes[0] = "OK"; codes[1] = "ERROR";
    codes[2] = "RING"; codes[3] = "NO CARRIER";

    tv[0]  = mk("", -1, 0, 0, -1);
    tv[1]  = mk("OK", -1, 1, 0, -1);
    tv[2]  = mk("NO CARRIER", -1, 4, 0, -1);
    tv[3]  = mk("ERRORX", -1, 0, 0, -1);
    tv[4]  = mk("OK", 0, 0, 0, -1);
    tv[5]  = mk("OK", -1, 1, 0, -1);
    tv[6]  = mk("AAAAAAAAAAAAAAAAAAAA", -1, 0, 1, -1);
    tv[7]  = mk("RING", -1, 3, 0, -1);
    tv[8]  = mk("ERROR", -1, 2, 0, -1);
    tv[9]  = mk("0123456789ABCDEF", -1, 0, 0, -1);
    tv[10] = mk("0123456789ABCDEFG", -1, 0, 1, -1);
    tv[11] = mk("+CSQ: 23,0", -1, 0, 0, 23);
    tv[12] = mk("+CSQ: 123,0", -1, 0, 0, -1);
    tv[13] = mk("OKX", -1, 0, 0, -1);

    rst_n = 1'b0;
    line_rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    b_valid = n_valid;
    b_ferr = n_ferr;
    rxq.delete();
    send_byte(8'h41, 1'b1);
    repeat (4) @(negedge clk);
    chk("byte41.valid", n_valid - b_valid, 1);
    chk("byte41.ferr", n_ferr - b_ferr, 0);
    chk("byte41.data", rxq.size() == 1 ? rxq[0] : 999,
        32'h41);
    lat = last_valid_cyc - last_fall;
    chk("byte41.latency",
        (lat >= 155 && lat <= 157) ? 156 : lat, 156);

    for (int i = 0; i < 14; i++) begin
      t = {};
      for (int j = 0; j < tv[i].len; j++)
        t.push_back(tv[i].txt[8*(tv[i].len-1-j) +: 8]);
`ifdef GSM_RX_CSQ_EN
      ec = tv[i].exp_csq;
`else
      ec = -1;
`endif
      send_line($sformatf("tv%0d", i), t,
                tv[i].bad_at, tv[i].exp_resp,
                tv[i].exp_ovf, ec);
    end

    for (int r = 0; r < 12; r++) begin
      int kind, n, ba;
      bit bad;
      kind = $urandom_range(0, 5);
      t = {};
      if (kind < 4) begin
        t = str_q(codes[kind]);
      end else if (kind == 4) begin
        n = $urandom_range(0, 18);
        repeat (n) begin
          if ($urandom_range(0, 9) == 0)
            t.push_back(8'h0D);
          else
            t.push_back(u8'(alpha[
              $urandom_range(0, alpha.len() - 1)]));
        end
      end else begin
        t = str_q(codes[$urandom_range(0, 3)]);
        if ($urandom_range(0, 1) == 1)
          t.push_back(u8'(alpha[
            $urandom_range(0, alpha.len() - 1)]));
        else
          void'(t.pop_front());
      end
      ba = -1;
      if (t.size() > 0 && $urandom_range(0, 4) == 0)
        ba = $urandom_range(0, t.size() - 1);
      bad = (ba >= 0);
      k = kept_of(t, ba);
`ifdef GSM_RX_CSQ_EN
      ec = csq_model(k, bad);
`else
      ec = -1;
`endif
      send_line($sformatf("rnd%0d", r), t, ba,
                model_resp(k, bad),
                k.size() > LINE_MAX ? 1 : 0, ec);
    end

    b_valid = n_valid;
    b_ferr = n_ferr;
    line_rx = 1'b0;
    repeat (8) @(negedge clk);
    line_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch.valid", n_valid - b_valid, 0);
    chk("glitch.ferr", n_ferr - b_ferr, 0);

    b_valid = n_valid;
    b_ferr = n_ferr;
    line_rx = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    line_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("break.ferr", n_ferr - b_ferr, 1);
    chk("break.valid", n_valid - b_valid, 0);
    send_line("break_flush", str_q(""), -1, 0, 0, -1);

    send_byte(8'h52, 1'b1);
    send_byte(8'h49, 1'b1);
    line_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    line_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    line_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_outs", outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    send_line("after_rst", str_q("OK"), -1, 1, 0, -1);

    chk("resp_exclusive", n_multi, 0);
`ifndef GSM_RX_CSQ_EN
    chk("csq_tied", 32'({csq_rssi, csq_valid}), 0);
    chk("csq_count", n_csq, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/gsm_rx.md
Name: gsm_rx

Overview:
- Receive-side companion to the GSM AT-command UART transmitter. Deserialises the modem's 8N1 UART output (line_rx).
- Assembles bytes into CR/LF-terminated lines and classifies each line as a final result code: OK, ERROR, RING or NO CARRIER.
- Gives the command sequencer a per-command completion handshake in place of blind fixed delays.

Parameters:
- CLKS_PER_BIT, 2500: clk cycles per UART bit. Default is 9600 baud at 24 MHz; minimum 8.
- LINE_MAX, 16: maximum buffered characters per line, CR/LF excluded.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- line_rx  in  1  UART serial input from the modem; asynchronous to clk; idles high
- rx_data  out  8  last received byte
- rx_valid  out  1  one-cycle pulse; rx_data is new
- frame_err  out  1  one-cycle pulse; stop bit sampled low
- resp_ok  out  1  one-cycle pulse; line equals "OK"
- resp_err  out  1  one-cycle pulse; line equals "ERROR"
- resp_ring  out  1  one-cycle pulse; line equals "RING"
- resp_nocar  out  1  one-cycle pulse; line equals "NO CARRIER"
- line_ovf  out  1  one-cycle pulse; line exceeded LINE_MAX
- csq_rssi  out  7  last parsed signal-quality value (optional feature)
- csq_valid  out  1  one-cycle pulse; csq_rssi updated (optional feature)

Behaviour:
- Reset values: all outputs 0; the synchroniser flops reset to 1; FSM in IDLE; line buffer empty.
- line_rx passes through a 2-flop synchroniser. All sampling uses the synchronised signal.

Bit FSM states:
- IDLE: on a synchronised 1->0 edge, clear the bit counter and go to START.
- START: wait CLKS_PER_BIT/2 cycles, then sample. If low, go to DATA. If high, treat as a glitch and return to IDLE with no output.
- DATA: sample every CLKS_PER_BIT cycles, LSB first, for 8 bits, then go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - Sample high: on the next cycle, rx_data is loaded and rx_valid pulses; go to IDLE.
  - Sample low: frame_err pulses, the byte is dropped, go to WAIT_HI.
- WAIT_HI: stay until the synchronised line is 1, then go to IDLE. A held-low break therefore yields exactly one frame_err.

Latency:
- rx_valid asserts CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 4 cycles (±1) after the falling edge of line_rx.

Line matcher:
- Consumes each rx_valid byte.
- CR (0x0D) is ignored.
- LF (0x0A) terminates the line. Any other byte is appended while count < LINE_MAX.
- Byte arriving at count == LINE_MAX: line_ovf pulses once and the line is marked bad.
- On LF:
  - Line good and non-empty: compare against the four codes (exact length and content). On a match, the corresponding resp_* pulses exactly one cycle after the LF's rx_valid.
  - Empty line, bad line, or no match: no pulse.
  - In every case, count and the bad flag clear.
- A frame_err marks the current line bad. That line yields no response pulse.
- At most one resp_* pulse per line. The resp_* outputs are mutually exclusive.
- Reset asserted mid-frame or mid-line returns everything to reset state immediately. The partial line is discarded.

Optional Feature:
- Macro: GSM_RX_CSQ_EN.
- Defined: lines of the form "+CSQ: " followed by 1-2 decimal digits and then "," are decoded.
  - Value = d or 10*d1+d0.
  - csq_rssi is loaded and csq_valid pulses in the same cycle a resp_* pulse would occur, i.e. one cycle after the LF.
  - Malformed lines (non-digit, 0 or >2 digits) cause no update.
- Not defined: csq_rssi and csq_valid are tied to 0; no parse logic is synthesised.

Decomposition:
- Package gsm_pkg:
  - ASCII constants CR, LF, COMMA, SPACE, PLUS.
  - The response code strings and their lengths.
  - Bit-FSM state enum: IDLE, START, DATA, STOP, WAIT_HI.
  - Default CLKS_PER_BIT.
- Sub-module gsm_uart_rx: synchroniser plus bit FSM. Outputs rx_data, rx_valid and frame_err.
- gsm_rx instantiates gsm_uart_rx and holds the line buffer, matcher and CSQ parser.

Test Plan (CLKS_PER_BIT=16):
- Send byte 0x41 with a good stop bit -> rx_data=0x41, one rx_valid pulse, frame_err=0.
- Send "\r\nOK\r\n" -> exactly one resp_ok pulse, one cycle after the final LF's rx_valid; other resp_* stay 0.
- Send "NO CARRIER\r\n" then "ERRORX\r\n" -> one resp_nocar pulse, then no pulse for the second line.
- Send 0x4F with the stop bit low, then "K\r\n" -> frame_err pulses once, no resp_ok; a following "OK\r\n" yields resp_ok.
- Send 20 'A' bytes then LF -> line_ovf pulses once, no resp_*; a following "RING\r\n" yields resp_ring.
- Apply an 8-cycle low glitch -> no rx_valid. Assert rst_n low mid-DATA, then send "OK\r\n" -> normal resp_ok.
- With GSM_RX_CSQ_EN defined, send "+CSQ: 23,0\r\n" -> csq_rssi=23 and one csq_valid pulse.
